// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : stall/flush sequencer for the 5-stage pipeline (PC plus IF/ID, ID/EX, EX/MEM, MEM/WB buffers).
// Latency : all controls are combinational from registered state plus same-cycle hazard inputs.
// Backpres: mem_busy freezes every buffer; a multiply holds PC..EX/MEM and bubbles MEM/WB.
//
// Optional feature macro: HAZ_PERF_CNT_EN builds saturating stall/flush perf counters.
// Without it, stall_cycles and flush_count are tied to zero.
//
// Ports
//   clk, reset                        clock (rising edge), asynchronous active-low reset
//   id_rs1/id_rs2, id_use_rs1/2       ID source registers and whether they are read
//   ex_rd, ex_is_load, ex_mul_start   EX destination, load flag, first cycle of a multiply
//   branch_taken, mem_busy            EX taken branch, data memory not ready
//   pc_w_en, *_w_en, *_bubble         PC and per-buffer write enables / bubble inserts
//   ctrl_state                        RUN=0, MUL_WAIT=1, MEM_WAIT=2
//   stall_cycles, flush_count         perf counters
module pipeline_hazard_ctrl #(
   parameter int REG_AW  = 5,
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_is_load,
   input  logic              ex_mul_start,
   input  logic              branch_taken,
   input  logic              mem_busy,
   output logic              pc_w_en,
   output logic              ifid_w_en,
   output logic              ifid_bubble,
   output logic              idex_w_en,
   output logic              idex_bubble,
   output logic              exmem_w_en,
   output logic              exmem_bubble,
   output logic              memwb_w_en,
   output logic              memwb_bubble,
   output logic [1:0]        ctrl_state,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_count
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MUL_WAIT = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_t;

   localparam int MC_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
   localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MUL_LAT - 2);
   localparam logic [MC_W-1:0] MC_ONE  = MC_W'(1);

   state_t          state_q, state_d;
   state_t          saved_q, saved_d;
   logic [MC_W-1:0] mul_cnt_q, mul_cnt_d;
   logic            load_use;
   logic            branch_hon;

   assign load_use = ex_is_load && (ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

   assign ctrl_state = state_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_RUN;
         saved_q   <= ST_RUN;
         mul_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         saved_q   <= saved_d;
         mul_cnt_q <= mul_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      saved_d      = saved_q;
      mul_cnt_d    = mul_cnt_q;
      branch_hon   = 1'b0;
      pc_w_en      = 1'b1;
      ifid_w_en    = 1'b1;
      ifid_bubble  = 1'b0;
      idex_w_en    = 1'b1;
      idex_bubble  = 1'b0;
      exmem_w_en   = 1'b1;
      exmem_bubble = 1'b0;
      memwb_w_en   = 1'b1;
      memwb_bubble = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mem_busy) begin
               {pc_w_en, ifid_w_en, idex_w_en, exmem_w_en, memwb_w_en} = '0;
               saved_d = ST_RUN;
               state_d = ST_MEM_WAIT;
            end else if (ex_mul_start) begin
               {pc_w_en, ifid_w_en, idex_w_en, exmem_w_en} = '0;
               memwb_bubble = 1'b1;
               mul_cnt_d    = MC_LOAD;
               // With MUL_LAT==2 the start cycle alone is the whole hold.
               state_d      = (MUL_LAT > 2) ? ST_MUL_WAIT : ST_RUN;
            end else if (branch_taken) begin
               // Squash IF/ID and ID/EX; a coincident load-use stall is moot
               // because the stalled instruction is being discarded.
               ifid_bubble = 1'b1;
               idex_bubble = 1'b1;
               branch_hon  = 1'b1;
            end else if (load_use) begin
               pc_w_en     = 1'b0;
               ifid_w_en   = 1'b0;
               idex_bubble = 1'b1;
            end
         end

         ST_MUL_WAIT: begin
            if (mem_busy) begin
               // Count is frozen while the memory wait is serviced.
               {pc_w_en, ifid_w_en, idex_w_en, exmem_w_en, memwb_w_en} = '0;
               saved_d = ST_MUL_WAIT;
               state_d = ST_MEM_WAIT;
            end else begin
               {pc_w_en, ifid_w_en, idex_w_en, exmem_w_en} = '0;
               memwb_bubble = 1'b1;
               // Leave as the count reaches zero so the EX hold, including the
               // start cycle, totals MUL_LAT-1 cycles.
               if (mul_cnt_q <= MC_ONE) begin
                  mul_cnt_d = '0;
                  state_d   = ST_RUN;
               end else begin
                  mul_cnt_d = mul_cnt_q - MC_ONE;
               end
            end
         end

         ST_MEM_WAIT: begin
            if (mem_busy) begin
               {pc_w_en, ifid_w_en, idex_w_en, exmem_w_en, memwb_w_en} = '0;
            end else begin
               // Memory completed: pipeline advances this cycle, other
               // same-cycle events are left for the datapath to re-present.
               state_d = saved_q;
            end
         end

         default: begin
            state_d = ST_RUN;
         end
      endcase

      // Reset forces every control quiet regardless of inputs.
      if (!reset) begin
         {pc_w_en, ifid_w_en, idex_w_en, exmem_w_en, memwb_w_en}    = '0;
         {ifid_bubble, idex_bubble, exmem_bubble, memwb_bubble}     = '0;
         branch_hon = 1'b0;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (!pc_w_en && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
         end
         if (branch_hon && (flush_count != '1)) begin
            flush_count <= flush_count + 1'b1;
         end
      end
   end
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule
